// File: rtl/common_types.sv
`default_nettype none
// ============================================================================
// Module      : common_types (package)
// Description : Shared types for the 6502 instruction encoder: address/data
//               widths, bus direction, mnemonic and addressing-mode enums,
//               encoder FSM states and an instruction-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package common_types;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } rw_t;

    // Mnemonics grouped by their opcode family so the encoder can decode them
    // by range; _uopc_ marks an unknown/unsupported mnemonic.
    typedef enum logic [5:0] {
        ORA, AND, EOR, ADC, STA, LDA, CMP, SBC,
        ASL, ROL, LSR, ROR, STX, LDX, DEC, INC,
        BIT, JMP, STY, LDY, CPY, CPX,
        BPL, BMI, BVC, BVS, BCC, BCS, BNE, BEQ,
        JSR,
        BRK, PHP, CLC, PLP, SEC, RTI, PHA, CLI, RTS, PLA, SEI, DEY, TXA,
        TYA, TXS, TAY, TAX, CLV, TSX, INY, DEX, CLD, INX, NOP, SED,
        HLT, _uopc_
    } opc_t;

    // INDY is used as the absolute-indirect form (only JMP accepts it).
    typedef enum logic [3:0] {
        IMP, ACC, IMM, ZP, ZPX, ZPY, IXID, IDIX, REL,
        ABS, ABSX, ABSY, INDY, _uaddmod_
    } addmod_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT_OP = 2'd1,
        EMIT_LO = 2'd2,
        EMIT_HI = 2'd3
    } enc_state_t;

    // Instruction length in bytes implied by the addressing mode alone.
    function automatic logic [1:0] mode_length(input addmod_t m);
        logic [1:0] len;
        case (m)
            IMP, ACC:                          len = 2'd1;
            IMM, ZP, ZPX, ZPY, IXID, IDIX, REL: len = 2'd2;
            ABS, ABSX, ABSY, INDY:             len = 2'd3;
            default:                           len = 2'd1;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/opc_encode.sv
`default_nettype none
// ============================================================================
// Module      : opc_encode
// Description : Combinational NMOS 6502 opcode encoder. Maps a mnemonic and
//               addressing mode to the opcode byte, instruction length and a
//               legality flag for the pair.
// Revision    : 1.0 - initial release
// ============================================================================
module opc_encode
    import common_types::*;
(
    input  opc_t       i_opc,
    input  addmod_t    i_mode,
    output data_t      o_byte,
    output logic [1:0] o_length,
    output logic       o_legal
);

    localparam logic [2:0] c_K_BAD = 3'd0;  // unknown mnemonic
    localparam logic [2:0] c_K_G1  = 3'd1;  // aaabbb01 ALU group
    localparam logic [2:0] c_K_G2  = 3'd2;  // aaabbb10 shift/X group
    localparam logic [2:0] c_K_G0  = 3'd3;  // aaabbb00 BIT/Y/compare group
    localparam logic [2:0] c_K_BR  = 3'd4;  // xxy10000 branches
    localparam logic [2:0] c_K_JMP = 3'd5;
    localparam logic [2:0] c_K_JSR = 3'd6;
    localparam logic [2:0] c_K_IMP = 3'd7;  // single-byte table

    logic [2:0] w_kind;
    logic [2:0] w_aaa;
    logic [2:0] w_bbb;
    logic       w_ok;
    data_t      w_tbl;

    // Classify the mnemonic into its opcode family and extract its aaa field.
    always_comb begin
        w_kind = c_K_BAD;
        w_aaa  = 3'd0;
        w_tbl  = 8'h00;
        case (i_opc)
            ORA: begin w_kind = c_K_G1; w_aaa = 3'd0; end
            AND: begin w_kind = c_K_G1; w_aaa = 3'd1; end
            EOR: begin w_kind = c_K_G1; w_aaa = 3'd2; end
            ADC: begin w_kind = c_K_G1; w_aaa = 3'd3; end
            STA: begin w_kind = c_K_G1; w_aaa = 3'd4; end
            LDA: begin w_kind = c_K_G1; w_aaa = 3'd5; end
            CMP: begin w_kind = c_K_G1; w_aaa = 3'd6; end
            SBC: begin w_kind = c_K_G1; w_aaa = 3'd7; end
            ASL: begin w_kind = c_K_G2; w_aaa = 3'd0; end
            ROL: begin w_kind = c_K_G2; w_aaa = 3'd1; end
            LSR: begin w_kind = c_K_G2; w_aaa = 3'd2; end
            ROR: begin w_kind = c_K_G2; w_aaa = 3'd3; end
            STX: begin w_kind = c_K_G2; w_aaa = 3'd4; end
            LDX: begin w_kind = c_K_G2; w_aaa = 3'd5; end
            DEC: begin w_kind = c_K_G2; w_aaa = 3'd6; end
            INC: begin w_kind = c_K_G2; w_aaa = 3'd7; end
            BIT: begin w_kind = c_K_G0; w_aaa = 3'd1; end
            STY: begin w_kind = c_K_G0; w_aaa = 3'd4; end
            LDY: begin w_kind = c_K_G0; w_aaa = 3'd5; end
            CPY: begin w_kind = c_K_G0; w_aaa = 3'd6; end
            CPX: begin w_kind = c_K_G0; w_aaa = 3'd7; end
            BPL: begin w_kind = c_K_BR; w_aaa = 3'd0; end
            BMI: begin w_kind = c_K_BR; w_aaa = 3'd1; end
            BVC: begin w_kind = c_K_BR; w_aaa = 3'd2; end
            BVS: begin w_kind = c_K_BR; w_aaa = 3'd3; end
            BCC: begin w_kind = c_K_BR; w_aaa = 3'd4; end
            BCS: begin w_kind = c_K_BR; w_aaa = 3'd5; end
            BNE: begin w_kind = c_K_BR; w_aaa = 3'd6; end
            BEQ: begin w_kind = c_K_BR; w_aaa = 3'd7; end
            JMP: w_kind = c_K_JMP;
            JSR: w_kind = c_K_JSR;
            BRK: begin w_kind = c_K_IMP; w_tbl = 8'h00; end
            PHP: begin w_kind = c_K_IMP; w_tbl = 8'h08; end
            CLC: begin w_kind = c_K_IMP; w_tbl = 8'h18; end
            PLP: begin w_kind = c_K_IMP; w_tbl = 8'h28; end
            SEC: begin w_kind = c_K_IMP; w_tbl = 8'h38; end
            RTI: begin w_kind = c_K_IMP; w_tbl = 8'h40; end
            PHA: begin w_kind = c_K_IMP; w_tbl = 8'h48; end
            CLI: begin w_kind = c_K_IMP; w_tbl = 8'h58; end
            RTS: begin w_kind = c_K_IMP; w_tbl = 8'h60; end
            PLA: begin w_kind = c_K_IMP; w_tbl = 8'h68; end
            SEI: begin w_kind = c_K_IMP; w_tbl = 8'h78; end
            DEY: begin w_kind = c_K_IMP; w_tbl = 8'h88; end
            TXA: begin w_kind = c_K_IMP; w_tbl = 8'h8A; end
            TYA: begin w_kind = c_K_IMP; w_tbl = 8'h98; end
            TXS: begin w_kind = c_K_IMP; w_tbl = 8'h9A; end
            TAY: begin w_kind = c_K_IMP; w_tbl = 8'hA8; end
            TAX: begin w_kind = c_K_IMP; w_tbl = 8'hAA; end
            CLV: begin w_kind = c_K_IMP; w_tbl = 8'hB8; end
            TSX: begin w_kind = c_K_IMP; w_tbl = 8'hBA; end
            INY: begin w_kind = c_K_IMP; w_tbl = 8'hC8; end
            DEX: begin w_kind = c_K_IMP; w_tbl = 8'hCA; end
            CLD: begin w_kind = c_K_IMP; w_tbl = 8'hD8; end
            INX: begin w_kind = c_K_IMP; w_tbl = 8'hE8; end
            NOP: begin w_kind = c_K_IMP; w_tbl = 8'hEA; end
            SED: begin w_kind = c_K_IMP; w_tbl = 8'hF8; end
            HLT: begin w_kind = c_K_IMP; w_tbl = 8'h02; end
            default: w_kind = c_K_BAD;
        endcase
    end

    // Pick the bbb field for the mode, check the pair is a real NMOS opcode
    // and assemble the byte.
    always_comb begin
        w_bbb    = 3'd0;
        w_ok     = 1'b0;
        o_byte   = 8'h00;
        o_length = mode_length(i_mode);
        case (w_kind)
            c_K_G1: begin
                w_ok = 1'b1;
                case (i_mode)
                    IXID:    w_bbb = 3'd0;
                    ZP:      w_bbb = 3'd1;
                    IMM:     begin w_bbb = 3'd2; w_ok = (i_opc != STA); end
                    ABS:     w_bbb = 3'd3;
                    IDIX:    w_bbb = 3'd4;
                    ZPX:     w_bbb = 3'd5;
                    ABSY:    w_bbb = 3'd6;
                    ABSX:    w_bbb = 3'd7;
                    default: w_ok  = 1'b0;
                endcase
                o_byte = {w_aaa, w_bbb, 2'b01};
            end
            c_K_G2: begin
                // STX/LDX (aaa 4/5) index with Y where the others use X.
                case (i_mode)
                    IMM:     begin w_bbb = 3'd0; w_ok = (w_aaa == 3'd5); end
                    ZP:      begin w_bbb = 3'd1; w_ok = 1'b1; end
                    ACC:     begin w_bbb = 3'd2; w_ok = (w_aaa < 3'd4); end
                    ABS:     begin w_bbb = 3'd3; w_ok = 1'b1; end
                    ZPX:     begin w_bbb = 3'd5; w_ok = (w_aaa != 3'd4) && (w_aaa != 3'd5); end
                    ZPY:     begin w_bbb = 3'd5; w_ok = (w_aaa == 3'd4) || (w_aaa == 3'd5); end
                    ABSX:    begin w_bbb = 3'd7; w_ok = (w_aaa != 3'd4) && (w_aaa != 3'd5); end
                    ABSY:    begin w_bbb = 3'd7; w_ok = (w_aaa == 3'd5); end
                    default: w_ok = 1'b0;
                endcase
                o_byte = {w_aaa, w_bbb, 2'b10};
            end
            c_K_G0: begin
                case (i_mode)
                    IMM:     begin w_bbb = 3'd0; w_ok = (w_aaa >= 3'd5); end
                    ZP:      begin w_bbb = 3'd1; w_ok = 1'b1; end
                    ABS:     begin w_bbb = 3'd3; w_ok = 1'b1; end
                    ZPX:     begin w_bbb = 3'd5; w_ok = (w_aaa == 3'd4) || (w_aaa == 3'd5); end
                    ABSX:    begin w_bbb = 3'd7; w_ok = (w_aaa == 3'd5); end
                    default: w_ok = 1'b0;
                endcase
                o_byte = {w_aaa, w_bbb, 2'b00};
            end
            c_K_BR: begin
                w_ok   = (i_mode == REL);
                o_byte = {w_aaa, 5'b10000};
            end
            c_K_JMP: begin
                w_ok   = (i_mode == ABS) || (i_mode == INDY);
                o_byte = (i_mode == INDY) ? 8'h6C : 8'h4C;
            end
            c_K_JSR: begin
                w_ok   = (i_mode == ABS);
                o_byte = 8'h20;
            end
            c_K_IMP: begin
                w_ok   = (i_mode == IMP);
                o_byte = w_tbl;
            end
            default: w_ok = 1'b0;
        endcase
        o_legal = w_ok;
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Accepts 6502 instruction descriptors and writes the encoded
//               bytes (opcode, operand low, operand high) one per cycle to a
//               byte-wide memory port, advancing a 16-bit write pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
    import common_types::*;
#(
    parameter addr_t RESET_ORG = 16'h0000
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    org_valid,
    input  addr_t   org_addr,
    input  logic    in_valid,
    output logic    in_ready,
    input  opc_t    in_opc,
    input  addmod_t in_mode,
    input  addr_t   in_operand,
    output addr_t   mem_addr,
    output data_t   mem_data,
    output rw_t     mem_rw,
    output logic    mem_we,
    output logic    err,
    output addr_t   pc
);

    enc_state_t r_state;
    enc_state_t w_next_state;

    addr_t      r_pc;
    data_t      r_opcode;
    logic [1:0] r_len;
    addr_t      r_operand;
    addr_t      r_mem_addr;
    data_t      r_mem_data;
    rw_t        r_mem_rw;
    logic       r_mem_we;
    logic       r_err;

    data_t      w_enc_byte;
    logic [1:0] w_enc_len;
    logic       w_enc_legal;
    logic       w_idle;
    logic       w_accept;
    logic       w_emit;
    data_t      w_emit_data;

    opc_encode u_opc_encode (
        .i_opc    (in_opc),
        .i_mode   (in_mode),
        .o_byte   (w_enc_byte),
        .o_length (w_enc_len),
        .o_legal  (w_enc_legal)
    );

    assign w_idle   = (r_state == IDLE);
    assign w_accept = in_valid && w_idle;
    assign w_emit   = !w_idle;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and the byte the current emit state puts on the bus.
    always_comb begin
        w_next_state = r_state;
        w_emit_data  = r_opcode;
        case (r_state)
            IDLE: begin
                if (w_accept && w_enc_legal) begin
                    w_next_state = EMIT_OP;
                end
            end
            EMIT_OP: begin
                w_emit_data = r_opcode;
                if (r_len == 2'd1) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = EMIT_LO;
                end
            end
            EMIT_LO: begin
                w_emit_data = r_operand[7:0];
                if (r_len == 2'd2) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = EMIT_HI;
                end
            end
            EMIT_HI: begin
                w_emit_data  = r_operand[15:8];
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: write pointer, latched instruction and registered bus/err.
    // Each emit state's byte is registered at the end of that state, so a
    // reset during a later state cancels every byte not yet registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_ORG;
            r_opcode   <= 8'h00;
            r_len      <= 2'd0;
            r_operand  <= 16'h0000;
            r_mem_addr <= 16'h0000;
            r_mem_data <= 8'h00;
            r_mem_rw   <= READ;
            r_mem_we   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err    <= w_accept && !w_enc_legal;
            r_mem_we <= w_emit;
            r_mem_rw <= w_emit ? WRITE : READ;
            if (w_emit) begin
                r_mem_addr <= r_pc;
                r_mem_data <= w_emit_data;
                r_pc       <= r_pc + 16'd1;
            end else begin
                // Origin load applies before the first byte of an
                // instruction accepted in the same cycle.
                if (org_valid) begin
                    r_pc <= org_addr;
                end
                if (w_accept && w_enc_legal) begin
                    r_opcode  <= w_enc_byte;
                    r_len     <= w_enc_len;
                    r_operand <= in_operand;
                end
            end
        end
    end

    assign in_ready = w_idle;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign mem_rw   = r_mem_rw;
    assign mem_we   = r_mem_we;
    assign err      = r_err;
    assign pc       = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed self-checking bench for instr_encoder. A monitor
//               records every byte write; each scenario compares the recorded
//               writes, pc and err pulses with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
    import common_types::*;

    localparam addr_t c_RESET_ORG = 16'hC000;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    logic    org_valid = 1'b0;
    addr_t   org_addr = 16'h0000;
    logic    in_valid = 1'b0;
    logic    in_ready;
    opc_t    in_opc = NOP;
    addmod_t in_mode = IMP;
    addr_t   in_operand = 16'h0000;
    addr_t   mem_addr;
    data_t   mem_data;
    rw_t     mem_rw;
    logic    mem_we;
    logic    err;
    addr_t   pc;

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    logic [24:0] wr_q[$];

    instr_encoder #(.RESET_ORG(c_RESET_ORG)) dut (
        .clk        (clk),
        .rst        (rst),
        .org_valid  (org_valid),
        .org_addr   (org_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opc     (in_opc),
        .in_mode    (in_mode),
        .in_operand (in_operand),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_rw     (mem_rw),
        .mem_we     (mem_we),
        .err        (err),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    // Record each written byte as {rw, addr, data} and count err cycles.
    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_q.push_back({mem_rw, mem_addr, mem_data});
        if (err === 1'b1) err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_test();
        @(negedge clk);
        wr_q.delete();
        err_seen = 0;
    endtask

    task automatic set_org(input addr_t a);
        @(negedge clk);
        org_valid = 1'b1;
        org_addr  = a;
        @(posedge clk);
        #1 org_valid = 1'b0;
    endtask

    // Present one descriptor; returns 1 time unit after the accepting edge.
    task automatic issue(input opc_t o, input addmod_t m, input addr_t opnd,
                         input logic ov, input addr_t oa);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        in_opc     = o;
        in_mode    = m;
        in_operand = opnd;
        org_valid  = ov;
        org_addr   = oa;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        org_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
    endtask

    task automatic check_wr(input int i, input addr_t a, input data_t d);
        if (i < wr_q.size()) begin
            check($sformatf("wr%0d_addr", i), {16'd0, wr_q[i][23:8]}, {16'd0, a});
            check($sformatf("wr%0d_data", i), {24'd0, wr_q[i][7:0]}, {24'd0, d});
            check($sformatf("wr%0d_rw", i), {31'd0, wr_q[i][24]}, 32'd1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_we",    {31'd0, mem_we}, 32'd0);
        check("rst_rw",    {31'd0, mem_rw}, 32'd0);
        check("rst_addr",  {16'd0, mem_addr}, 32'h0000);
        check("rst_data",  {24'd0, mem_data}, 32'h00);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_pc",    {16'd0, pc}, {16'd0, c_RESET_ORG});

        // LDA #$42 at 0200
        set_org(16'h0200);
        start_test();
        issue(LDA, IMM, 16'h0042, 1'b0, 16'h0000);
        drain();
        check("lda_cnt", wr_q.size(), 32'd2);
        check_wr(0, 16'h0200, 8'hA9);
        check_wr(1, 16'h0201, 8'h42);
        check("lda_pc", {16'd0, pc}, 32'h0202);

        // STA $1234 then ASL A
        start_test();
        issue(STA, ABS, 16'h1234, 1'b0, 16'h0000);
        issue(ASL, ACC, 16'h0000, 1'b0, 16'h0000);
        drain();
        check("sta_cnt", wr_q.size(), 32'd4);
        check_wr(0, 16'h0202, 8'h8D);
        check_wr(1, 16'h0203, 8'h34);
        check_wr(2, 16'h0204, 8'h12);
        check_wr(3, 16'h0205, 8'h0A);
        check("asl_pc", {16'd0, pc}, 32'h0206);

        // STA #imm is illegal: one err pulse, nothing written
        start_test();
        issue(STA, IMM, 16'h0077, 1'b0, 16'h0000);
        drain();
        check("ill_err", err_seen, 32'd1);
        check("ill_cnt", wr_q.size(), 32'd0);
        check("ill_pc", {16'd0, pc}, 32'h0206);
        check("ill_ready", {31'd0, in_ready}, 32'd1);

        // Unknown addressing mode also errors
        start_test();
        issue(LDA, _uaddmod_, 16'h0000, 1'b0, 16'h0000);
        drain();
        check("umode_err", err_seen, 32'd1);
        check("umode_cnt", wr_q.size(), 32'd0);

        // LDX $10,Y
        start_test();
        issue(LDX, ZPY, 16'h0010, 1'b0, 16'h0000);
        drain();
        check("ldx_cnt", wr_q.size(), 32'd2);
        check_wr(0, 16'h0206, 8'hB6);
        check_wr(1, 16'h0207, 8'h10);
        check("ldx_pc", {16'd0, pc}, 32'h0208);

        // JMP $8000 at FFFF wraps pc
        set_org(16'hFFFF);
        start_test();
        issue(JMP, ABS, 16'h8000, 1'b0, 16'h0000);
        drain();
        check("jmp_cnt", wr_q.size(), 32'd3);
        check_wr(0, 16'hFFFF, 8'h4C);
        check_wr(1, 16'h0000, 8'h00);
        check_wr(2, 16'h0001, 8'h80);
        check("jmp_pc", {16'd0, pc}, 32'h0002);
        check("jmp_err", err_seen, 32'd0);

        // JSR $4000 aborted by reset during EMIT_LO
        set_org(16'h0300);
        start_test();
        issue(JSR, ABS, 16'h4000, 1'b0, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b1;
        check("jsr_busy", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        drain();
        check("jsr_cnt", wr_q.size(), 32'd1);
        check_wr(0, 16'h0300, 8'h20);
        check("jsr_pc", {16'd0, pc}, {16'd0, c_RESET_ORG});
        check("jsr_ready", {31'd0, in_ready}, 32'd1);

        // org_valid during EMIT_OP is ignored
        start_test();
        issue(LDA, IMM, 16'h0055, 1'b0, 16'h0000);
        org_valid = 1'b1;
        org_addr  = 16'h9000;
        @(posedge clk);
        #1 org_valid = 1'b0;
        drain();
        check("orgign_cnt", wr_q.size(), 32'd2);
        check_wr(0, 16'hC000, 8'hA9);
        check_wr(1, 16'hC001, 8'h55);
        check("orgign_pc", {16'd0, pc}, 32'hC002);

        // org_valid together with accept: NOP lands at org_addr
        start_test();
        issue(NOP, IMP, 16'h0000, 1'b1, 16'h5000);
        drain();
        check("orgacc_cnt", wr_q.size(), 32'd1);
        check_wr(0, 16'h5000, 8'hEA);
        check("orgacc_pc", {16'd0, pc}, 32'h5001);

        // JMP ($1234), BEQ, HLT
        start_test();
        issue(JMP, INDY, 16'h1234, 1'b0, 16'h0000);
        issue(BEQ, REL, 16'h00FE, 1'b0, 16'h0000);
        issue(HLT, IMP, 16'h0000, 1'b0, 16'h0000);
        drain();
        check("mix_cnt", wr_q.size(), 32'd6);
        check_wr(0, 16'h5001, 8'h6C);
        check_wr(1, 16'h5002, 8'h34);
        check_wr(2, 16'h5003, 8'h12);
        check_wr(3, 16'h5004, 8'hF0);
        check_wr(4, 16'h5005, 8'hFE);
        check_wr(5, 16'h5006, 8'h02);
        check("mix_pc", {16'd0, pc}, 32'h5007);
        check("idle_we", {31'd0, mem_we}, 32'd0);
        check("idle_rw", {31'd0, mem_rw}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter: RESET_ORG, 16'h0000, write address loaded at reset.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: org_valid  input  1  load new write origin.
REQ-005 SHALL have port: org_addr  input  addr_t  origin value.
REQ-006 SHALL have port: in_valid  input  1  instruction descriptor present.
REQ-007 SHALL have port: in_ready  output  1  encoder idle, can accept.
REQ-008 SHALL have port: in_opc  input  opc_t  mnemonic.
REQ-009 SHALL have port: in_mode  input  addmod_t  addressing mode.
REQ-010 SHALL have port: in_operand  input  addr_t  operand; low byte only for 2-byte forms.
REQ-011 SHALL have port: mem_addr  output  addr_t  write address.
REQ-012 SHALL have port: mem_data  output  data_t  write byte.
REQ-013 SHALL have port: mem_rw  output  rw_t  Write while mem_we, else Read.
REQ-014 SHALL have port: mem_we  output  1  byte strobe, one byte per cycle.
REQ-015 SHALL have port: err  output  1  one-cycle pulse, illegal opc/mode pair.
REQ-016 SHALL have port: pc  output  addr_t  next write address.

Function
REQ-017 SHALL encode (opc_t, addmod_t) to the NMOS 6502 opcode byte: the aaabbbcc groups for ORA..SBC, ASL..INC, BIT..CPY, the branch pattern, and a table for single-byte/JSR/JMP forms; INDY means JMP indirect (6C); HLT encodes to 02.
REQ-018 SHALL set length 1 for IMP/ACC, 2 for IMM/ZP/ZPX/ZPY/IXID/IDIX/REL, 3 for ABS/ABSX/ABSY/INDY.
REQ-019 SHALL run FSM enc_state_t {IDLE, EMIT_OP, EMIT_LO, EMIT_HI}; in_ready=1 only in IDLE.
REQ-020 SHALL accept when in_valid & in_ready; latch opcode, length, operand; go to EMIT_OP.
REQ-021 SHALL in each EMIT state drive mem_we=1, mem_rw=Write, mem_addr=pc, mem_data=opcode/operand[7:0]/operand[15:8], then pc+1.
REQ-022 SHALL transition EMIT_OP->IDLE (len 1), ->EMIT_LO (len 2,3); EMIT_LO->IDLE (len 2) or ->EMIT_HI; EMIT_HI->IDLE; an N-byte instruction occupies N+1 cycles incl. accept.
REQ-023 SHALL wrap pc FFFF->0000 without error.
REQ-024 SHALL, on illegal pair or _uopc_/_uaddmod_, accept, pulse err the next cycle, write nothing, leave pc unchanged, stay IDLE.
REQ-025 SHALL honour org_valid only in IDLE; ignore it otherwise.
REQ-026 SHALL, on org_valid and accept in the same cycle, write the instruction starting at org_addr.
REQ-027 SHALL register mem_addr, mem_data, mem_rw, mem_we, err; they hold last values with mem_we=0 when idle.

Reset
REQ-028 SHALL on rst: state IDLE, pc=RESET_ORG, mem_we=0, mem_rw=Read, mem_addr=0000, mem_data=00, err=0, in_ready=1 next cycle.
REQ-029 SHALL abort an instruction mid-emission on rst; no further byte written.
REQ-030 SHALL give rst priority over org_valid and in_valid.

Structure
REQ-031 SHALL place enc_state_t in common_types, reusing addr_t, data_t, opc_t, addmod_t, rw_t.
REQ-032 SHALL isolate encoding in combinational sub-module opc_encode (opc, mode -> byte, length, legal).

Verification
REQ-033 SHALL test: org 0200, LDA IMM 0042 -> 0200:A9, 0201:42, pc=0202.
REQ-034 SHALL test: STA ABS 1234 -> A:8D, A+1:34, A+2:12; then ASL ACC -> single 0A.
REQ-035 SHALL test: STA IMM -> err pulse, no mem_we, pc unchanged; then LDX ZPY 0010 -> B6 10.
REQ-036 SHALL test: org FFFF, JMP ABS 8000 -> FFFF:4C, 0000:00, 0001:80, pc=0002.
REQ-037 SHALL test: JSR 4000 with rst in EMIT_LO cycle -> only opcode 20 written, pc=RESET_ORG.
REQ-038 SHALL test: org_valid in EMIT_OP ignored; org_valid+in_valid in IDLE -> writes at org_addr.
